// File: rtl/floo_route_hdr_stage.sv
// Route header stage: passes the request address to the translation logic,
// builds a route header from the translation result and the local source ID,
// and holds it in a two-entry elastic buffer toward flit packing.
//
// state  | meaning
// -------+-------------------------------------------
// EMPTY  | no entry buffered, valid_o low
// FULL1  | one entry buffered, can accept and deliver
// FULL2  | both entries buffered, ready_o low
module floo_route_hdr_stage #(
  parameter type         id_t        = logic,
  parameter type         mask_sel_t  = logic,
  parameter type         addr_t      = logic,
  parameter type         payload_t   = logic,
  parameter bit          EnMultiCast = 1'b0,
  parameter bit          DropOnErr   = 1'b0,
  parameter int unsigned ErrCntWidth = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  id_t                    src_id_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  addr_t                  addr_i,
  input  payload_t               payload_i,
  output addr_t                  xlat_addr_o,
  output logic                   xlat_valid_o,
  input  id_t                    xlat_id_i,
  input  mask_sel_t              xlat_mask_x_i,
  input  mask_sel_t              xlat_mask_y_i,
  input  logic                   xlat_err_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output id_t                    hdr_src_id_o,
  output id_t                    hdr_dst_id_o,
  output mask_sel_t              hdr_mask_x_o,
  output mask_sel_t              hdr_mask_y_o,
  output logic                   hdr_err_o,
  output payload_t               payload_o,
  output logic [ErrCntWidth-1:0] err_cnt_o
);

  typedef struct packed {
    id_t       src_id;
    id_t       dst_id;
    mask_sel_t mask_x;
    mask_sel_t mask_y;
    logic      err;
    payload_t  payload;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL1 = 2'd1,
    FULL2 = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  entry_t                 mem_q [2];
  entry_t                 entry_d;
  logic [ErrCntWidth-1:0] err_cnt_q, err_cnt_d;
  logic                   acc, dlv, enq;

  assign xlat_addr_o  = addr_i;
  assign xlat_valid_o = valid_i;

  // ready_o looks only at registered occupancy, so no path from ready_i
  assign ready_o = ~rst_i & (state_q != FULL2);
  assign valid_o = (state_q != EMPTY);

  assign acc = valid_i & ready_o;
  assign dlv = valid_o & ready_i;
  // errored requests still complete their handshake when dropped
  assign enq = acc & ~(DropOnErr & xlat_err_i);

  // Build the entry; a failed decode never carries translation results
  always_comb begin
    entry_d         = '0;
    entry_d.src_id  = src_id_i;
    entry_d.err     = xlat_err_i;
    entry_d.payload = payload_i;
    if (!xlat_err_i) begin
      entry_d.dst_id = xlat_id_i;
      if (EnMultiCast) begin
        entry_d.mask_x = xlat_mask_x_i;
        entry_d.mask_y = xlat_mask_y_i;
      end
    end
  end

  // Occupancy FSM and pointer next-state
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (enq) wr_ptr_d = ~wr_ptr_q;
    if (dlv) rd_ptr_d = ~rd_ptr_q;
    case (state_q)
      EMPTY: if (enq) state_d = FULL1;
      FULL1: begin
        if (enq && !dlv)      state_d = FULL2;
        else if (!enq && dlv) state_d = EMPTY;
      end
      FULL2: if (dlv) state_d = FULL1;
      default: state_d = EMPTY;
    endcase
  end

  // Saturating decode-error counter next-state
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (acc && xlat_err_i && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ErrCntWidth'(1);
    end
  end

  // State, pointers, counter and entry storage; reset clears the entries too
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= EMPTY;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      err_cnt_q <= '0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      err_cnt_q <= err_cnt_d;
      if (enq) mem_q[wr_ptr_q] <= entry_d;
    end
  end

  assign hdr_src_id_o = mem_q[rd_ptr_q].src_id;
  assign hdr_dst_id_o = mem_q[rd_ptr_q].dst_id;
  assign hdr_mask_x_o = mem_q[rd_ptr_q].mask_x;
  assign hdr_mask_y_o = mem_q[rd_ptr_q].mask_y;
  assign hdr_err_o    = mem_q[rd_ptr_q].err;
  assign payload_o    = mem_q[rd_ptr_q].payload;
  assign err_cnt_o    = err_cnt_q;

endmodule
